reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
// - Circular in-order reorder buffer. It is the responder for rename's ROB allocation handshake
//   (rob_alloc_req/gnt/tags) and the producer of commit_write_ports, which feed the PRF and rename.
// - Allocates up to PIPE_WIDTH tags per cycle, captures CDB results, retires up to PIPE_WIDTH
//   completed entries in program order, and clears completely on flush.
// PARAMETERS
// - DEPTH      default ROB_ENTRIES (2**TAG_WIDTH)  number of entries; power of two; tag = entry index
// - CDB_PORTS  default PIPE_WIDTH                  number of CDB writeback ports
// PORTS
// - clk                 in   1                     clock; all state updates on posedge
// - rst                 in   1                     synchronous, active-high reset
// - flush               in   1                     synchronous squash of all entries
// - rob_alloc_req       in   PIPE_WIDTH            per-slot allocation request from rename
// - rob_alloc_en        in   1                     rename advancing this cycle; allocation happens only when high
// - rob_alloc_rd        in   5 x PIPE_WIDTH        arch destination per slot
// - rob_alloc_has_rd    in   PIPE_WIDTH            slot writes an arch register
// - rob_alloc_gnt       out  PIPE_WIDTH            per-slot grant; combinational
// - rob_alloc_tags      out  TAG_WIDTH x PIPE_WIDTH  tag per slot; combinational
// - cdb_ports           in   cdb_port_t x CDB_PORTS  {valid, tag, data} results from execute
// - commit_write_ports  out  prf_commit_write_port_t x PIPE_WIDTH  {we, addr, tag, data}; registered
// - rob_empty           out  1                     count == 0; registered
// - rob_full            out  1                     count == DEPTH; registered
// BEHAVIOUR
// - State: head/tail pointers of TAG_WIDTH+1 bits (MSB = wrap bit); count of $clog2(DEPTH)+1 bits.
//   Each entry is rob_entry_t {valid, done, rd, has_rd, data}.
// - Reset or flush, next cycle:
//   - head = tail = count = 0; every entry valid = done = 0.
//   - commit_write_ports all zero (we = 0).
//   - rob_empty = 1, rob_full = 0.
//   - flush wins over any alloc, CDB write or commit in the same cycle; nothing retires that cycle.
// - Grant is computed from the registered count only. It never depends on rob_alloc_en (no loop with rename).
//   - free  = DEPTH - count.
//   - gnt[0] = req[0] && free >= 1.
//   - gnt[1] = req[1] && free >= (req[0] ? 2 : 1).
// - Tags: tags[0] = tail[TAG_WIDTH-1:0]; tags[1] = tail + (req[0] ? 1 : 0), modulo DEPTH.
//   - With only req[1] set, slot 1 receives the tail tag.
// - Allocate on the clock edge: each slot with req & gnt & rob_alloc_en writes {valid=1, done=0, rd, has_rd}
//   at its tag. Tail advances by the number of such slots.
//   - With alloc_en = 0, nothing changes, even if gnt is high.
// - CDB writeback: for each port with valid, if entry[tag].valid, set done = 1 and data = cdb data.
//   - CDB to an invalid entry is ignored.
//   - Two ports never carry the same tag (upstream guarantee); the lower port index wins if they do.
// - Commit, evaluated on registered state:
//   - c0 = entry[head].valid && entry[head].done.
//   - c1 = c0 && entry[head+1].valid && entry[head+1].done.
//   - Retired entries clear valid; head advances by c0 + c1.
// - commit_write_ports[i] is registered, so it appears the cycle after the retire decision:
//   - we = ci && has_rd && rd != 0; addr = rd; tag = retired index; data = entry data.
//   - When ci = 0, the port is zero.
// - Latency: CDB write in cycle N sets done at N+1. If that entry is the head, it retires at N+1
//   and appears on commit_write_ports at N+2.
// - count_next = count + allocs - commits. A simultaneous alloc and commit is legal.
//   Freed slots are grantable from the next cycle only.
// - Wrap-around: pointer index wraps modulo DEPTH; the wrap bit toggles. full/empty come from count.
// - An entry allocated and CDB-written in the same cycle keeps allocate semantics (done = 0).
//   Upstream cannot issue an unallocated tag.
// STRUCTURE
// - uarch_pkg gains:
//   - rob_entry_t and cdb_port_t typedefs.
//   - ROB_ENTRIES = 2**TAG_WIDTH.
// - prf_commit_write_port_t, PIPE_WIDTH and TAG_WIDTH stay in uarch_pkg unchanged.
// - No sub-module: one entry array, pointer/count registers, grant/commit comb logic, output register.
// TESTING
// - Reset, then req=2'b11, alloc_en=1 -> gnt=11, tags={1,0}; next cycle count=2, rob_empty=0.
// - req=2'b10, alloc_en=1 with tail=5 -> gnt=10, tags[1]=5; tail becomes 6.
// - Fill to DEPTH-1, then req=11 -> gnt=01; next cycle rob_full=1, req=01 -> gnt=00.
// - Alloc tags 0,1 (rd=3,4). CDB tag1 data=0xBB, then tag0 data=0xAA.
//   - Expect both on commit_write_ports in the same cycle: {we=1, addr=3, tag=0, data=0xAA}
//     and {we=1, addr=4, tag=1, data=0xBB}.
//   - Each appears 2 cycles after the tag-0 CDB write.
// - Entry with has_rd=0, or rd=0, done -> retires (head advances), we=0.
// - Flush with 6 valid entries, a CDB write and a pending commit -> next cycle count=0,
//   commit ports zero, tags[0]=0.

Source files
------------

// File: rtl/uarch_pkg.sv
// Shared micro-architecture types: pipeline width, tag width and the ROB, CDB and commit records.
package uarch_pkg;
   localparam int PIPE_WIDTH  = 2;
   localparam int TAG_WIDTH   = 4;
   localparam int ROB_ENTRIES = 2**TAG_WIDTH;
   localparam int DATA_W      = 32;

   typedef struct packed {
      logic                 we;
      logic [4:0]           addr;
      logic [TAG_WIDTH-1:0] tag;
      logic [DATA_W-1:0]    data;
   } prf_commit_write_port_t;

   typedef struct packed {
      logic                 valid;
      logic [TAG_WIDTH-1:0] tag;
      logic [DATA_W-1:0]    data;
   } cdb_port_t;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic [4:0]        rd;
      logic              has_rd;
      logic [DATA_W-1:0] data;
   } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: grants and tags allocations, captures CDB results,
// retires up to PIPE_WIDTH completed entries per cycle in program order, squashes on flush.
module reorder_buffer
   import uarch_pkg::*;
#(
   parameter int DEPTH     = ROB_ENTRIES,
   parameter int CDB_PORTS = PIPE_WIDTH
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   flush,
   input  logic [PIPE_WIDTH-1:0]                  rob_alloc_req,
   input  logic                                   rob_alloc_en,
   input  logic [PIPE_WIDTH-1:0][4:0]             rob_alloc_rd,
   input  logic [PIPE_WIDTH-1:0]                  rob_alloc_has_rd,
   output logic [PIPE_WIDTH-1:0]                  rob_alloc_gnt,
   output logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0]   rob_alloc_tags,
   input  cdb_port_t [CDB_PORTS-1:0]              cdb_ports,
   output prf_commit_write_port_t [PIPE_WIDTH-1:0] commit_write_ports,
   output logic                                   rob_empty,
   output logic                                   rob_full
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = TAG_WIDTH + 1;

   rob_entry_t           entries [DEPTH];
   logic [PTR_W-1:0]     head, tail;
   logic [CNT_W-1:0]     count, count_next, free, need, n_alloc, n_commit;
   logic [TAG_WIDTH-1:0] next_tag;
   logic [TAG_WIDTH-1:0] commit_idx [PIPE_WIDTH];
   logic [PIPE_WIDTH-1:0] alloc_fire, retire_p0;
   logic                 retire_run;

   // Grant looks only at the registered count so rename can use it without a loop through alloc_en.
   always_comb begin
      free          = CNT_W'(DEPTH) - count;
      need          = '0;
      next_tag      = tail[TAG_WIDTH-1:0];
      n_alloc       = '0;
      rob_alloc_gnt = '0;
      rob_alloc_tags = '0;
      alloc_fire    = '0;
      for (int i = 0; i < PIPE_WIDTH; i++) begin
         rob_alloc_tags[i] = next_tag;
         if (rob_alloc_req[i]) begin
            need             = need + CNT_W'(1);
            rob_alloc_gnt[i] = (free >= need);
            next_tag         = next_tag + TAG_WIDTH'(1);
         end
         alloc_fire[i] = rob_alloc_gnt[i] && rob_alloc_en;
         if (alloc_fire[i]) n_alloc = n_alloc + CNT_W'(1);
      end
   end

   // Stage 0: retire decision on the oldest entries, stopping at the first one not yet done.
   always_comb begin
      retire_run = 1'b1;
      n_commit   = '0;
      retire_p0  = '0;
      for (int i = 0; i < PIPE_WIDTH; i++) begin
         commit_idx[i] = head[TAG_WIDTH-1:0] + TAG_WIDTH'(i);
         retire_run    = retire_run && entries[commit_idx[i]].valid && entries[commit_idx[i]].done;
         retire_p0[i]  = retire_run;
         if (retire_run) n_commit = n_commit + CNT_W'(1);
      end
   end

   assign count_next = count + n_alloc - n_commit;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         rob_empty <= 1'b1;
         rob_full  <= 1'b0;
      end else begin
         head      <= head + PTR_W'(n_commit);
         tail      <= tail + PTR_W'(n_alloc);
         count     <= count_next;
         rob_empty <= (count_next == '0);
         rob_full  <= (count_next == CNT_W'(DEPTH));
      end
   end

   // Allocation is applied after CDB capture so a same-cycle CDB hit cannot mark a fresh entry done.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int e = 0; e < DEPTH; e++) begin
            entries[e].valid <= 1'b0;
            entries[e].done  <= 1'b0;
         end
      end else begin
         for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (cdb_ports[p].valid && entries[cdb_ports[p].tag].valid) begin
               entries[cdb_ports[p].tag].done <= 1'b1;
               entries[cdb_ports[p].tag].data <= cdb_ports[p].data;
            end
         end
         for (int i = 0; i < PIPE_WIDTH; i++) begin
            if (retire_p0[i]) entries[commit_idx[i]].valid <= 1'b0;
         end
         for (int i = 0; i < PIPE_WIDTH; i++) begin
            if (alloc_fire[i]) begin
               entries[rob_alloc_tags[i]].valid  <= 1'b1;
               entries[rob_alloc_tags[i]].done   <= 1'b0;
               entries[rob_alloc_tags[i]].rd     <= rob_alloc_rd[i];
               entries[rob_alloc_tags[i]].has_rd <= rob_alloc_has_rd[i];
            end
         end
      end
   end

   // Stage 1: registered commit write ports.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         commit_write_ports <= '0;
      end else begin
         for (int i = 0; i < PIPE_WIDTH; i++) begin
            if (retire_p0[i]) begin
               commit_write_ports[i].we   <= entries[commit_idx[i]].has_rd &&
                                             (entries[commit_idx[i]].rd != 5'd0);
               commit_write_ports[i].addr <= entries[commit_idx[i]].rd;
               commit_write_ports[i].tag  <= commit_idx[i];
               commit_write_ports[i].data <= entries[commit_idx[i]].data;
            end else begin
               commit_write_ports[i] <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and randomized bench for reorder_buffer, checked against a queue-based program-order model.
module tb_reorder_buffer;
   import uarch_pkg::*;

   localparam int DEPTH = ROB_ENTRIES;

   logic clk = 1'b0;
   logic rst, flush, en;
   logic [PIPE_WIDTH-1:0]                  req, has_rd, gnt;
   logic [PIPE_WIDTH-1:0][4:0]             rd;
   logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0]   tags;
   cdb_port_t [PIPE_WIDTH-1:0]             cdb;
   prf_commit_write_port_t [PIPE_WIDTH-1:0] cwp;
   logic rob_empty, rob_full;

   reorder_buffer dut (
      .clk(clk), .rst(rst), .flush(flush),
      .rob_alloc_req(req), .rob_alloc_en(en), .rob_alloc_rd(rd), .rob_alloc_has_rd(has_rd),
      .rob_alloc_gnt(gnt), .rob_alloc_tags(tags), .cdb_ports(cdb),
      .commit_write_ports(cwp), .rob_empty(rob_empty), .rob_full(rob_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                tag;
      logic [4:0]        rd;
      logic              has_rd;
      logic              done;
      logic [DATA_W-1:0] data;
   } ment_t;

   ment_t mq[$];
   int    mtail;
   prf_commit_write_port_t exp_cp [PIPE_WIDTH];
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_grant(output logic [PIPE_WIDTH-1:0] g,
                              output logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] t);
      int free, need, nxt;
      free = DEPTH - mq.size();
      need = 0;
      nxt  = mtail;
      for (int i = 0; i < PIPE_WIDTH; i++) begin
         t[i] = TAG_WIDTH'(nxt % DEPTH);
         g[i] = 1'b0;
         if (req[i]) begin
            need++;
            g[i] = (free >= need);
            nxt++;
         end
      end
   endtask

   task automatic model_edge();
      logic [PIPE_WIDTH-1:0] g;
      logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] t;
      int nret;
      ment_t m;
      model_grant(g, t);
      for (int i = 0; i < PIPE_WIDTH; i++) exp_cp[i] = '0;
      if (rst || flush) begin
         mq.delete();
         mtail = 0;
      end else begin
         nret = 0;
         while (nret < PIPE_WIDTH && nret < mq.size() && mq[nret].done) nret++;
         for (int i = 0; i < nret; i++) begin
            exp_cp[i].we   = mq[i].has_rd && (mq[i].rd != 5'd0);
            exp_cp[i].addr = mq[i].rd;
            exp_cp[i].tag  = TAG_WIDTH'(mq[i].tag);
            exp_cp[i].data = mq[i].data;
         end
         for (int p = PIPE_WIDTH - 1; p >= 0; p--) begin
            if (cdb[p].valid) begin
               for (int k = 0; k < mq.size(); k++) begin
                  if (mq[k].tag == int'(cdb[p].tag)) begin
                     mq[k].done = 1'b1;
                     mq[k].data = cdb[p].data;
                  end
               end
            end
         end
         for (int i = 0; i < nret; i++) void'(mq.pop_front());
         for (int i = 0; i < PIPE_WIDTH; i++) begin
            if (req[i] && en && g[i]) begin
               m.tag = mtail % DEPTH;
               m.rd = rd[i];
               m.has_rd = has_rd[i];
               m.done = 1'b0;
               m.data = '0;
               mq.push_back(m);
               mtail++;
            end
         end
      end
   endtask

   task automatic cycle(input bit do_comb);
      logic [PIPE_WIDTH-1:0] g;
      logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] t;
      #1;
      if (do_comb) begin
         model_grant(g, t);
         check("gnt", 64'(gnt), 64'(g));
         for (int i = 0; i < PIPE_WIDTH; i++) check($sformatf("tag%0d", i), 64'(tags[i]), 64'(t[i]));
      end
      model_edge();
      @(posedge clk);
      #1;
      for (int i = 0; i < PIPE_WIDTH; i++) check($sformatf("commit%0d", i), 64'(cwp[i]), 64'(exp_cp[i]));
      check("rob_empty", 64'(rob_empty), 64'(mq.size() == 0));
      check("rob_full", 64'(rob_full), 64'(mq.size() == DEPTH));
   endtask

   task automatic set_idle();
      flush = 1'b0; en = 1'b0; req = '0; rd = '0; has_rd = '0; cdb = '0;
   endtask

   task automatic alloc(input logic [PIPE_WIDTH-1:0] r);
      set_idle();
      req = r; en = 1'b1; has_rd = '1;
      rd[0] = 5'($urandom_range(1, 31));
      rd[1] = 5'($urandom_range(1, 31));
      cycle(1);
   endtask

   initial begin
      prf_commit_write_port_t e;
      int k0;
      int k1;
      mtail = 0;
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      cycle(0);
      cycle(0);
      rst = 1'b0;

      // Two-slot allocation from reset
      set_idle();
      req = 2'b11; en = 1'b1; rd[0] = 5'd1; rd[1] = 5'd2; has_rd = 2'b11;
      #1;
      check("reset_gnt", 64'(gnt), 64'(2'b11));
      check("reset_tag0", 64'(tags[0]), 64'(0));
      check("reset_tag1", 64'(tags[1]), 64'(1));
      cycle(1);
      check("after_alloc_empty", 64'(rob_empty), 64'(0));

      // Slot 1 alone takes the tail tag
      set_idle(); flush = 1'b1; cycle(1);
      alloc(2'b11); alloc(2'b11); alloc(2'b01);
      set_idle(); req = 2'b10; en = 1'b1; rd[1] = 5'd9; has_rd = 2'b10;
      #1;
      check("slot1_gnt", 64'(gnt), 64'(2'b10));
      check("slot1_tag", 64'(tags[1]), 64'(5));
      cycle(1);
      set_idle(); req = 2'b01;
      #1;
      check("tail_after_slot1", 64'(tags[0]), 64'(6));

      // Fill to DEPTH-1, then to full
      for (int i = 0; i < 4; i++) alloc(2'b11);
      alloc(2'b01);
      set_idle(); req = 2'b11; en = 1'b1; has_rd = 2'b11;
      #1;
      check("nearly_full_gnt", 64'(gnt), 64'(2'b01));
      cycle(1);
      check("full_flag", 64'(rob_full), 64'(1));
      set_idle(); req = 2'b01; en = 1'b1;
      #1;
      check("full_gnt", 64'(gnt), 64'(2'b00));
      cycle(1);

      // Flush with six entries, a CDB write and a pending commit
      set_idle(); flush = 1'b1; cycle(1);
      for (int i = 0; i < 3; i++) alloc(2'b11);
      set_idle(); cdb[0] = '{valid: 1'b1, tag: 4'd0, data: 32'h1234}; cycle(1);
      set_idle(); flush = 1'b1; req = 2'b11; en = 1'b1;
      cdb[0] = '{valid: 1'b1, tag: 4'd1, data: 32'h5678};
      cycle(1);
      check("flush_empty", 64'(rob_empty), 64'(1));
      check("flush_commit0", 64'(cwp[0]), 64'(0));
      check("flush_commit1", 64'(cwp[1]), 64'(0));
      set_idle(); req = 2'b01;
      #1;
      check("flush_tag0", 64'(tags[0]), 64'(0));

      // Out-of-order completion retires together in order
      set_idle(); req = 2'b11; en = 1'b1; rd[0] = 5'd3; rd[1] = 5'd4; has_rd = 2'b11; cycle(1);
      set_idle(); cdb[0] = '{valid: 1'b1, tag: 4'd1, data: 32'hBB}; cycle(1);
      set_idle(); cdb[0] = '{valid: 1'b1, tag: 4'd0, data: 32'hAA}; cycle(1);
      check("ooo_not_yet", 64'(cwp[0].we), 64'(0));
      set_idle(); cycle(1);
      e.we = 1'b1; e.addr = 5'd3; e.tag = 4'd0; e.data = 32'hAA;
      check("ooo_commit0", 64'(cwp[0]), 64'(e));
      e.we = 1'b1; e.addr = 5'd4; e.tag = 4'd1; e.data = 32'hBB;
      check("ooo_commit1", 64'(cwp[1]), 64'(e));

      // No-destination and x0 destinations retire without a write
      set_idle(); req = 2'b11; en = 1'b1; rd[0] = 5'd7; rd[1] = 5'd0; has_rd = 2'b10; cycle(1);
      set_idle();
      cdb[0] = '{valid: 1'b1, tag: 4'd2, data: 32'h11};
      cdb[1] = '{valid: 1'b1, tag: 4'd3, data: 32'h22};
      cycle(1);
      set_idle(); cycle(1);
      check("nord_we0", 64'(cwp[0].we), 64'(0));
      check("nord_tag0", 64'(cwp[0].tag), 64'(2));
      check("nord_we1", 64'(cwp[1].we), 64'(0));
      check("nord_tag1", 64'(cwp[1].tag), 64'(3));
      check("nord_empty", 64'(rob_empty), 64'(1));

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         set_idle();
         req    = PIPE_WIDTH'($urandom);
         en     = ($urandom_range(0, 3) != 0);
         rd[0]  = 5'($urandom);
         rd[1]  = 5'($urandom);
         has_rd = PIPE_WIDTH'($urandom);
         flush  = ($urandom_range(0, 63) == 0);
         k0 = -1;
         if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
            k0 = $urandom_range(0, mq.size() - 1);
            cdb[0] = '{valid: 1'b1, tag: TAG_WIDTH'(mq[k0].tag), data: $urandom};
         end
         if ($urandom_range(0, 2) == 0) begin
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) k1 = mq[$urandom_range(0, mq.size() - 1)].tag;
            else k1 = $urandom_range(0, DEPTH - 1);
            if (k0 < 0 || k1 != mq[k0].tag)
               cdb[1] = '{valid: 1'b1, tag: TAG_WIDTH'(k1), data: $urandom};
         end
         cycle(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
